// File: rtl/execute_pkg.sv
// ---------------------------------------------------------------------------
// execute_pkg
// Shared definitions for the execute stage and its store FIFO:
//   - opcode constants recognised by execute (all others are no-ops here)
//   - width of one register-file entry and the bit offsets of its fields
//     entry layout: {valid, retr, locked, tag[15:0], val[15:0]}
// ---------------------------------------------------------------------------
package execute_pkg;

    localparam logic [3:0] OP_PLUS  = 4'h1;
    localparam logic [3:0] OP_MINUS = 4'h2;
    localparam logic [3:0] OP_BRZ   = 4'h5;

    localparam int RF_ENTRY_W = 35;
    localparam int VALID_BIT  = 34;
    localparam int RETR_BIT   = 33;
    localparam int LOCKED_BIT = 32;
    localparam int TAG_MSB    = 31;
    localparam int TAG_LSB    = 16;
    localparam int VAL_MSB    = 15;
    localparam int VAL_LSB    = 0;

endpackage

// File: rtl/execute_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Store FIFO holding {address, data} pairs waiting for the memory port.
// Pushes are refused when full unless a pop happens in the same cycle, and
// pops are refused when empty, so the FIFO can never overflow or underflow.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push, i_data  write request and 32-bit payload
//   i_pop           remove the head entry
//   o_data          head entry (stable until popped)
//   o_count         number of stored entries (0..DEPTH)
//   o_empty, o_full occupancy flags
// DEPTH must be a power of two (pointers wrap by natural overflow).
// ---------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [31:0]              i_data,
    output logic [31:0]              o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_LEVEL);
    assign w_doPop  = i_pop && !o_empty;
    // A full FIFO may still accept a push when the head leaves this cycle.
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_data   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Storage array; no reset needed since occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/execute.sv
// ---------------------------------------------------------------------------
// execute
// Execute stage: registers one instruction from select, performs PLUS/MINUS
// (16-bit wrapping increment/decrement of the operand) and BRZ (branch when
// operand is zero). Arithmetic results are written back combinationally into
// the first valid+locked register-file entry whose tag matches the pointer.
// Optional write-through path (macro EXECUTE_WRITE_THROUGH_EN) queues every
// arithmetic result into a store FIFO that drives the memory write port and
// back-pressures upstream when nearly full. Without the macro the memory
// outputs and stall_out are tied to 0 and mem_wr_ready is ignored.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ins, ptr, val, stall_in     instruction, pointer, operand, select stall
//   rf_in / rf_out              current / next register-file state
//   branch_en, branch_target    taken-branch pulse and destination
//   stall_out                   back-pressure to upstream stages
//   mem_wr_en/addr/data         memory write request
//   mem_wr_ready                memory accepts the write request
// ---------------------------------------------------------------------------
module execute
    import execute_pkg::*;
#(
    parameter int NCORES   = 4,
    parameter int WB_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  ins,
    input  logic [15:0]                  ptr,
    input  logic [15:0]                  val,
    input  logic                         stall_in,
    input  logic [NCORES*RF_ENTRY_W-1:0] rf_in,
    output logic [NCORES*RF_ENTRY_W-1:0] rf_out,
    output logic                         branch_en,
    output logic [15:0]                  branch_target,
    output logic                         stall_out,
    output logic                         mem_wr_en,
    output logic [15:0]                  mem_wr_addr,
    output logic [15:0]                  mem_wr_data,
    input  logic                         mem_wr_ready
);

    logic        r_exValid;
    logic [15:0] r_exIns;
    logic [15:0] r_exPtr;
    logic [15:0] r_exVal;
    logic        r_branchD1;

    logic        w_capture;
    logic        w_branchEn;
    logic        w_stallOut;
    logic        w_isArith;
    logic [3:0]  w_exOp;
    logic [15:0] w_result;
    logic        w_hit;
    logic [NCORES*RF_ENTRY_W-1:0] w_rfOut;

    assign w_exOp     = r_exIns[15:12];
    assign w_isArith  = r_exValid && ((w_exOp == OP_PLUS) || (w_exOp == OP_MINUS));
    assign w_result   = (w_exOp == OP_PLUS) ? (r_exVal + 16'd1) : (r_exVal - 16'd1);
    assign w_branchEn = r_exValid && (w_exOp == OP_BRZ) && (r_exVal == 16'h0000);

    // Nothing is captured while a branch is in flight or one cycle after it,
    // which squashes the two wrong-path instructions select still presents.
    assign w_capture  = !stall_in && !w_stallOut && !w_branchEn && !r_branchD1;

    assign branch_en     = w_branchEn;
    assign branch_target = {4'h0, r_exIns[11:0]};
    assign stall_out     = w_stallOut;
    assign rf_out        = w_rfOut;

    // Stage register plus the delayed branch flag; a cycle without capture
    // leaves a bubble (ex_valid low) rather than holding the old instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exValid  <= 1'b0;
            r_branchD1 <= 1'b0;
            r_exIns    <= '0;
            r_exPtr    <= '0;
            r_exVal    <= '0;
        end else begin
            r_branchD1 <= w_branchEn;
            r_exValid  <= w_capture;
            if (w_capture) begin
                r_exIns <= ins;
                r_exPtr <= ptr;
                r_exVal <= val;
            end
        end
    end

    // Writeback: pass the register file through untouched except for the
    // lowest-indexed valid, locked entry whose tag equals the pointer, which
    // receives the result and is unlocked.
    always_comb begin
        w_rfOut = rf_in;
        w_hit   = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_isArith && !w_hit
                && rf_in[i*RF_ENTRY_W + VALID_BIT]
                && rf_in[i*RF_ENTRY_W + LOCKED_BIT]
                && (rf_in[i*RF_ENTRY_W + TAG_LSB +: 16] == r_exPtr)) begin
                w_rfOut[i*RF_ENTRY_W + VAL_LSB +: 16] = w_result;
                w_rfOut[i*RF_ENTRY_W + LOCKED_BIT]    = 1'b0;
                w_hit = 1'b1;
            end
        end
    end

`ifdef EXECUTE_WRITE_THROUGH_EN
    localparam int CW = $clog2(WB_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(WB_DEPTH - 1);

    logic          w_fifoPop;
    logic          w_fifoEmpty;
    logic          w_fifoFull;
    logic [31:0]   w_fifoHead;
    logic [CW-1:0] w_fifoCount;

    assign w_fifoPop = !w_fifoEmpty && mem_wr_ready;

    wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wbFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_isArith),
        .i_pop   (w_fifoPop),
        .i_data  ({r_exPtr, w_result}),
        .o_data  (w_fifoHead),
        .o_count (w_fifoCount),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull)
    );

    // Stall one entry early so the op already in the stage always has room.
    assign w_stallOut  = (w_fifoCount >= STALL_LEVEL);
    assign mem_wr_en   = !w_fifoEmpty;
    assign mem_wr_addr = w_fifoHead[31:16];
    assign mem_wr_data = w_fifoHead[15:0];

    logic w_unusedFull;
    assign w_unusedFull = w_fifoFull;
`else
    logic w_unusedReady;
    assign w_unusedReady = mem_wr_ready;

    assign w_stallOut  = 1'b0;
    assign mem_wr_en   = 1'b0;
    assign mem_wr_addr = 16'h0000;
    assign mem_wr_data = 16'h0000;
`endif

endmodule

// File: tb/tb_execute.sv
// ---------------------------------------------------------------------------
// tb_execute
// Directed self-checking bench for the execute stage. Each task drives one
// scenario and compares outputs against hand-computed values. FIFO-specific
// scenarios are built only when EXECUTE_WRITE_THROUGH_EN is defined; the
// default build instead checks that the memory path stays tied off.
// ---------------------------------------------------------------------------
module tb_execute;

    localparam int NC  = 4;
    localparam int RFW = NC * 35;

    logic           clk;
    logic           rst;
    logic [15:0]    ins;
    logic [15:0]    ptr;
    logic [15:0]    val;
    logic           stall_in;
    logic [RFW-1:0] rf_in;
    logic [RFW-1:0] rf_out;
    logic           branch_en;
    logic [15:0]    branch_target;
    logic           stall_out;
    logic           mem_wr_en;
    logic [15:0]    mem_wr_addr;
    logic [15:0]    mem_wr_data;
    logic           mem_wr_ready;

    int checks;
    int errors;

    execute #(
        .NCORES   (NC),
        .WB_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ins           (ins),
        .ptr           (ptr),
        .val           (val),
        .stall_in      (stall_in),
        .rf_in         (rf_in),
        .rf_out        (rf_out),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .stall_out     (stall_out),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_ready  (mem_wr_ready)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [34:0] mkEntry(input logic v, input logic r, input logic l,
                                            input logic [15:0] t, input logic [15:0] d);
        return {v, r, l, t, d};
    endfunction

    // Advance past one rising edge and settle, so checks sample mid-cycle.
    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle(input int n);
        stall_in = 1'b1;
        repeat (n) tick;
    endtask

    task test_reset;
        rst = 1'b1;
        stall_in = 1'b0;
        ins = 16'h1000; ptr = 16'h0010; val = 16'h0001;
        rf_in = '0;
        rf_in[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b1, 16'h0010, 16'h1234);
        mem_wr_ready = 1'b0;
        tick; tick;
        checks++;
        if (branch_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_branch_en got %b want 0", branch_en); end
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr_en got %b want 0", mem_wr_en); end
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_out got %b want 0", stall_out); end
        checks++;
        if (rf_out !== rf_in) begin errors++; $display("[TB] FAIL reset_rf got %h want %h", rf_out, rf_in); end
        rst = 1'b0;
        idle(2);
    endtask

    task test_plus;
        logic [RFW-1:0] exp;
        rf_in = '0;
        rf_in[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b1, 16'h0010, 16'h00FF);
        mem_wr_ready = 1'b1;
        ins = 16'h1000; ptr = 16'h0010; val = 16'h00FF; stall_in = 1'b0;
        tick;
        stall_in = 1'b1;
        exp = rf_in;
        exp[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0100);
        checks++;
        if (rf_out !== exp) begin errors++; $display("[TB] FAIL plus_rf got %h want %h", rf_out, exp); end
        tick;
        checks++;
        if (rf_out !== rf_in) begin errors++; $display("[TB] FAIL plus_rf_after got %h want %h", rf_out, rf_in); end
`ifdef EXECUTE_WRITE_THROUGH_EN
        checks++;
        if (mem_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL plus_wr_en got %b want 1", mem_wr_en); end
        checks++;
        if (mem_wr_addr !== 16'h0010) begin errors++; $display("[TB] FAIL plus_wr_addr got %h want 0010", mem_wr_addr); end
        checks++;
        if (mem_wr_data !== 16'h0100) begin errors++; $display("[TB] FAIL plus_wr_data got %h want 0100", mem_wr_data); end
        tick;
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL plus_drained got %b want 0", mem_wr_en); end
`else
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL plus_wr_en_tied got %b want 0", mem_wr_en); end
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL plus_stall_tied got %b want 0", stall_out); end
`endif
        idle(3);
    endtask

    task test_priority_wrap;
        logic [RFW-1:0] exp;
        // MINUS 0x0000 -> 0xFFFF; entry0 unlocked and entry2 later, so entry1 wins.
        rf_in = '0;
        rf_in[0*35 +: 35] = mkEntry(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1111);
        rf_in[1*35 +: 35] = mkEntry(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000);
        rf_in[2*35 +: 35] = mkEntry(1'b1, 1'b0, 1'b1, 16'h0020, 16'h2222);
        rf_in[3*35 +: 35] = mkEntry(1'b0, 1'b0, 1'b1, 16'h0020, 16'h3333);
        ins = 16'h2000; ptr = 16'h0020; val = 16'h0000; stall_in = 1'b0;
        tick;
        stall_in = 1'b1;
        exp = rf_in;
        exp[1*35 +: 35] = mkEntry(1'b1, 1'b1, 1'b0, 16'h0020, 16'hFFFF);
        checks++;
        if (rf_out !== exp) begin errors++; $display("[TB] FAIL minus_wrap_prio got %h want %h", rf_out, exp); end
        idle(3);
        // PLUS 0xFFFF -> 0x0000; invalid entry0 must be skipped.
        rf_in = '0;
        rf_in[0*35 +: 35] = mkEntry(1'b0, 1'b0, 1'b1, 16'h0030, 16'h4444);
        rf_in[2*35 +: 35] = mkEntry(1'b1, 1'b0, 1'b1, 16'h0030, 16'hFFFF);
        ins = 16'h1ABC; ptr = 16'h0030; val = 16'hFFFF; stall_in = 1'b0;
        tick;
        stall_in = 1'b1;
        exp = rf_in;
        exp[2*35 +: 35] = mkEntry(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
        checks++;
        if (rf_out !== exp) begin errors++; $display("[TB] FAIL plus_wrap got %h want %h", rf_out, exp); end
        idle(3);
    endtask

    task test_nomatch_nop;
        rf_in = '0;
        rf_in[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b1, 16'h0050, 16'h0007);
        ins = 16'h3000; ptr = 16'h0050; val = 16'h0007; stall_in = 1'b0;
        tick;
        stall_in = 1'b1;
        checks++;
        if (rf_out !== rf_in) begin errors++; $display("[TB] FAIL nop_rf got %h want %h", rf_out, rf_in); end
        tick;
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL nop_no_push got %b want 0", mem_wr_en); end
        ins = 16'h1000; ptr = 16'h0099; stall_in = 1'b0;
        tick;
        stall_in = 1'b1;
        checks++;
        if (rf_out !== rf_in) begin errors++; $display("[TB] FAIL nomatch_rf got %h want %h", rf_out, rf_in); end
        idle(3);
    endtask

    task test_branch;
        logic [RFW-1:0] exp;
        rf_in = '0;
        rf_in[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0040);
        ins = 16'h5123; ptr = 16'h0000; val = 16'h0000; stall_in = 1'b0;
        tick;
        checks++;
        if (branch_en !== 1'b1) begin errors++; $display("[TB] FAIL brz_taken got %b want 1", branch_en); end
        checks++;
        if (branch_target !== 16'h0123) begin errors++; $display("[TB] FAIL brz_target got %h want 0123", branch_target); end
        ins = 16'h1000; ptr = 16'h0010; val = 16'h0040;
        tick;
        checks++;
        if (branch_en !== 1'b0) begin errors++; $display("[TB] FAIL brz_pulse got %b want 0", branch_en); end
        checks++;
        if (rf_out !== rf_in) begin errors++; $display("[TB] FAIL brz_squash1 got %h want %h", rf_out, rf_in); end
        tick;
        checks++;
        if (rf_out !== rf_in) begin errors++; $display("[TB] FAIL brz_squash2 got %h want %h", rf_out, rf_in); end
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL brz_squash_fifo got %b want 0", mem_wr_en); end
        tick;
        stall_in = 1'b1;
        exp = rf_in;
        exp[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0041);
        checks++;
        if (rf_out !== exp) begin errors++; $display("[TB] FAIL brz_resume got %h want %h", rf_out, exp); end
        idle(3);
        ins = 16'h5123; val = 16'h0001; stall_in = 1'b0;
        tick;
        stall_in = 1'b1;
        checks++;
        if (branch_en !== 1'b0) begin errors++; $display("[TB] FAIL brz_not_taken got %b want 0", branch_en); end
        idle(3);
    endtask

`ifdef EXECUTE_WRITE_THROUGH_EN
    task test_back_pressure;
        rf_in = '0;
        mem_wr_ready = 1'b0;
        stall_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ins = 16'h1000; ptr = 16'h0100 + 16'(k); val = 16'(k * 16);
            tick;
            if (k == 2) begin
                checks++;
                if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_count2 got %b want 0", stall_out); end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (stall_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall k=%0d got %b want 1", k, stall_out); end
            end
        end
        stall_in = 1'b1;
        tick;
        mem_wr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'h0100 + 16'(j) || mem_wr_data !== 16'(j * 16 + 1)) begin
                errors++;
                $display("[TB] FAIL bp_drain%0d got en=%b %h/%h want 1 %h/%h", j, mem_wr_en,
                         mem_wr_addr, mem_wr_data, 16'h0100 + 16'(j), 16'(j * 16 + 1));
            end
            tick;
        end
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got %b want 0", mem_wr_en); end
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_unstall got %b want 0", stall_out); end
        idle(2);
    endtask
`endif

    task test_reset_midop;
        logic [RFW-1:0] exp;
        rf_in = '0;
        rf_in[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0005);
        mem_wr_ready = 1'b0;
        ins = 16'h1000; ptr = 16'h0040; val = 16'h0005; stall_in = 1'b0;
        tick; tick; tick;
        exp = rf_in;
        exp[0 +: 35] = mkEntry(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0006);
        checks++;
        if (rf_out !== exp) begin errors++; $display("[TB] FAIL midop_pre got %h want %h", rf_out, exp); end
        rst = 1'b1;
        tick;
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midop_wr_en got %b want 0", mem_wr_en); end
        checks++;
        if (branch_en !== 1'b0) begin errors++; $display("[TB] FAIL midop_branch got %b want 0", branch_en); end
        checks++;
        if (rf_out !== rf_in) begin errors++; $display("[TB] FAIL midop_rf got %h want %h", rf_out, rf_in); end
        rst = 1'b0;
        stall_in = 1'b1;
        tick;
        checks++;
        if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midop_discard got %b want 0", mem_wr_en); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_plus;
        test_priority_wrap;
        test_nomatch_nop;
        test_branch;
`ifdef EXECUTE_WRITE_THROUGH_EN
        test_back_pressure;
`endif
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameter NCORES, default 4: number of register-file entries; each entry is 35 bits {valid, retr, locked, tag[15:0], val[15:0]}, with entry i at bits [i*35 +: 35].
REQ-002 Parameter WB_DEPTH, default 4: store-FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ins  in  16  instruction from select; opcode is ins[15:12], immediate is ins[11:0].
REQ-007 ptr  in  16  data-pointer value that accompanies ins.
REQ-008 val  in  16  operand value delivered by select.
REQ-009 stall_in  in  1  select stall; while high, ins, ptr and val are not valid.
REQ-010 rf_in  in  NCORES*35  current register-file state.
REQ-011 rf_out  out  NCORES*35  next register-file state.
REQ-012 branch_en  out  1  taken-branch pulse to fetch and select.
REQ-013 branch_target  out  16  branch destination.
REQ-014 stall_out  out  1  back-pressure to upstream stages.
REQ-015 mem_wr_en, mem_wr_addr[15:0], mem_wr_data[15:0]  out  memory write request.
REQ-016 mem_wr_ready  in  1  memory accepts the write request.

Function
REQ-017 Opcodes: PLUS=4'h1, MINUS=4'h2, BRZ=4'h5; every other opcode SHALL be a no-op in this stage.
REQ-018 Capture condition: the stage register loads {ins, ptr, val} with ex_valid=1 iff stall_in=0, stall_out=0, branch_en=0 and branch_en_d1=0; otherwise ex_valid=0 on the next edge.
REQ-019 branch_en_d1 SHALL be branch_en delayed one cycle, matching the two-cycle squash window used by select.
REQ-020 Result width is 16 bits, wrapping: PLUS gives ex_val+1 (0xFFFF->0x0000); MINUS gives ex_val-1 (0x0000->0xFFFF).
REQ-021 Default passthrough: rf_out SHALL equal rf_in in every entry not written under REQ-022.
REQ-022 Writeback: while ex_valid and ex_op is PLUS or MINUS, the first entry (lowest index) with valid=1, locked=1 and tag==ex_ptr SHALL have val=result and locked=0 on rf_out, in the same cycle (combinational).
REQ-023 If no entry matches under REQ-022, rf_out SHALL equal rf_in unchanged.
REQ-024 branch_en SHALL be asserted iff ex_valid, ex_op==BRZ and ex_val==16'h0000; this gives one-cycle latency from capture.
REQ-025 branch_target SHALL equal {4'h0, ex_imm}; its value is don't-care while branch_en=0.
REQ-026 Store FIFO: one push per PLUS or MINUS with ex_valid, carrying {ex_ptr, result}; one pop per cycle with mem_wr_en=1 and mem_wr_ready=1.
REQ-027 FIFO outputs: mem_wr_en = FIFO not empty; mem_wr_addr and mem_wr_data are the head entry, and SHALL be held stable until accepted.
REQ-028 stall_out SHALL be 1 iff FIFO count >= WB_DEPTH-1; this reserves one slot for the in-flight op.
REQ-029 Simultaneous push and pop SHALL leave count unchanged, including when the FIFO is full; the FIFO SHALL never overflow or underflow.

Reset
REQ-030 On rst: ex_valid=0, branch_en_d1=0, FIFO count=0 and pointers=0.
REQ-031 Consequently during reset: branch_en=0, mem_wr_en=0, stall_out=0, rf_out=rf_in.
REQ-032 Reset mid-operation SHALL discard the staged instruction and all queued writes.

Configuration
REQ-033 Macro EXECUTE_WRITE_THROUGH_EN: when defined, the store FIFO and memory write path are built as specified above.
REQ-034 When EXECUTE_WRITE_THROUGH_EN is undefined: no FIFO is built; mem_wr_en, mem_wr_addr and mem_wr_data are tied to 0; stall_out is tied to 0; mem_wr_ready is ignored; RF writeback is unchanged.

Structure
REQ-035 The shared package SHALL hold: the opcode constants, RF_ENTRY_W=35, and the entry field offsets (VALID=34, RETR=33, LOCKED=32, TAG=31:16, VAL=15:0).
REQ-036 The FIFO SHALL be the sub-module wb_fifo (parameter DEPTH, 32-bit data, push/pop/count), instantiated only under EXECUTE_WRITE_THROUGH_EN.

Verification
REQ-037 PLUS: entry0 {v=1, l=1, tag=0x0010, val=0x00FF}, ins=0x1000, ptr=0x0010, val=0x00FF -> next cycle rf_out entry0 val=0x0100, locked=0; one FIFO entry {0x0010, 0x0100}.
REQ-038 Wrap: MINUS with val=0x0000 -> result 0xFFFF; PLUS with val=0xFFFF -> result 0x0000.
REQ-039 Branch: BRZ ins=0x5123 with val=0 -> branch_en=1 for one cycle, branch_target=0x0123; the next two presented instructions are dropped (no RF or FIFO change). BRZ with val=1 -> branch_en stays 0.
REQ-040 Back-pressure (WB_DEPTH=4, mem_wr_ready=0): three PLUS ops -> stall_out=1 after count reaches 3; the fourth op completes; count=4; no overflow; raising mem_wr_ready drains in FIFO order.
REQ-041 Reset mid-op: assert rst with ex_valid=1 and FIFO count=2 -> next cycle mem_wr_en=0, branch_en=0, rf_out==rf_in.
REQ-042 Build without EXECUTE_WRITE_THROUGH_EN: the PLUS scenario updates RF, mem_wr_en stays 0, stall_out stays 0.
